// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave endpoint.
package spi_pkg;

  localparam int unsigned SPI_WIDTH = 8;

  // Level driven on miso while not selected; tristating is done at the top level.
  localparam logic SPI_IDLE_MISO = 1'b1;

  typedef enum logic {
    IDLE,
    ACTIVE
  } spi_slave_state_t;

endpackage

// File: rtl/spi_pin_sync.sv
// Multi-stage synchronizer for an asynchronous pin, followed by an edge register
// that yields single-cycle rise/fall detects in the clk domain.
module spi_pin_sync #(
  parameter int unsigned Stages = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pin_i,
  output logic sync_o,
  output logic rise_o,
  output logic fall_o
);

  logic [Stages-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain plus one edge-history flop; everything clears to 0 so a
  // pin already low at reset release never produces a falling edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[Stages-2:0], pin_i};
      prev_q <= sync_q[Stages-1];
    end
  end

  assign sync_o = sync_q[Stages-1];
  assign rise_o = sync_q[Stages-1] & ~prev_q;
  assign fall_o = ~sync_q[Stages-1] & prev_q;

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave, MSB first, 8-bit frames. Pins are oversampled in the clk
// domain; received bytes are strobed upstream and transmit bytes are requested
// with a one-cycle pulse.
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sck,
  input  logic                 ss,
  input  logic                 mosi,
  output logic                 miso,
  input  logic [SPI_WIDTH-1:0] data_in,
  output logic                 tx_req,
  output logic [SPI_WIDTH-1:0] data_out,
  output logic                 new_data,
  output logic                 busy
);

  localparam int unsigned CntW = $clog2(SPI_WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(SPI_WIDTH - 1);

  logic sck_sync, sck_rise, sck_fall;
  logic ss_sync, ss_rise, ss_fall;
  logic mosi_sync, mosi_rise, mosi_fall;

  spi_pin_sync #(.Stages(SYNC_STAGES)) u_sync_sck (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (sck),
    .sync_o (sck_sync),
    .rise_o (sck_rise),
    .fall_o (sck_fall)
  );

  spi_pin_sync #(.Stages(SYNC_STAGES)) u_sync_ss (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (ss),
    .sync_o (ss_sync),
    .rise_o (ss_rise),
    .fall_o (ss_fall)
  );

  // Same depth as the sck path so mosi_sync lines up with sck_rise.
  spi_pin_sync #(.Stages(SYNC_STAGES)) u_sync_mosi (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (mosi),
    .sync_o (mosi_sync),
    .rise_o (mosi_rise),
    .fall_o (mosi_fall)
  );

  logic unused_sync;
  assign unused_sync = ^{sck_sync, ss_sync, mosi_rise, mosi_fall};

  spi_slave_state_t     state_q, state_d;
  logic [CntW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [SPI_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [SPI_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [SPI_WIDTH-1:0] data_out_q, data_out_d;
  logic                 new_data_q, new_data_d;
  logic                 tx_req_q, tx_req_d;

  // State, counter, shift and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      rx_shift_q <= '0;
      tx_shift_q <= '0;
      data_out_q <= '0;
      new_data_q <= 1'b0;
      tx_req_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_shift_q <= rx_shift_d;
      tx_shift_q <= tx_shift_d;
      data_out_q <= data_out_d;
      new_data_q <= new_data_d;
      tx_req_q   <= tx_req_d;
    end
  end

  // Next-state logic: ss_rise outranks any sck edge seen in the same cycle.
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_shift_d = rx_shift_q;
    tx_shift_d = tx_shift_q;
    data_out_d = data_out_q;
    new_data_d = 1'b0;
    tx_req_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d    = ACTIVE;
          tx_shift_d = data_in;
          tx_req_d   = 1'b1;
          bit_cnt_d  = '0;
        end
      end
      ACTIVE: begin
        if (ss_rise) begin
          // Abort or normal end: any partial byte is dropped.
          state_d    = IDLE;
          bit_cnt_d  = '0;
          rx_shift_d = '0;
        end else if (sck_rise) begin
          rx_shift_d = {rx_shift_q[SPI_WIDTH-2:0], mosi_sync};
          bit_cnt_d  = bit_cnt_q + CntW'(1);
          if (bit_cnt_q == LastBit) begin
            data_out_d = {rx_shift_q[SPI_WIDTH-2:0], mosi_sync};
            new_data_d = 1'b1;
            tx_shift_d = data_in;
            tx_req_d   = 1'b1;
          end
        end else if (sck_fall && (bit_cnt_q != '0)) begin
          // Skipping the shift at a byte boundary keeps the freshly loaded MSB.
          tx_shift_d = {tx_shift_q[SPI_WIDTH-2:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign miso     = (state_q == ACTIVE) ? tx_shift_q[SPI_WIDTH-1] : SPI_IDLE_MISO;
  assign busy     = (state_q == ACTIVE);
  assign data_out = data_out_q;
  assign new_data = new_data_q;
  assign tx_req   = tx_req_q;

endmodule
